// File: rtl/hms_time_cnt.sv
// ----------------------------------------------------------------------------
// hms_time_cnt
//   Wall-clock time base: hours/minutes/seconds counter with a two-button
//   set mode. The 1 Hz rate is a one-cycle enable derived from a prescaler;
//   everything runs in the single clk domain.
//
//   Handshake note: there are no valid/ready channels here. The button inputs
//   are raw asynchronous levels; each is synchronized, debounced and turned
//   into a one-cycle press pulse. o_sec_tick is a one-cycle strobe with no
//   back-pressure.
//
// Parameters
//   TICK_DIV    clk cycles per second tick (>= 2)
//   DEB_CYC     consecutive stable cycles needed to accept a button level (>= 1)
//
// Ports
//   clk         in   system clock
//   rst         in   synchronous active-high reset
//   i_btn_mode  in   raw mode button (active-high, asynchronous)
//   i_btn_inc   in   raw increment button (active-high, asynchronous)
//   o_sec       out  seconds 0..59
//   o_min       out  minutes 0..59
//   o_hour      out  hours 0..23
//   o_mode      out  FSM state: 0=RUN 1=SET_HOUR 2=SET_MIN 3=SET_SEC
//   o_dp        out  decimal points, [0]=sec ones .. [5]=hour tens, 1=lit
//   o_sec_tick  out  one-cycle pulse in the cycle a running second elapses
// ----------------------------------------------------------------------------
module hms_time_cnt #(
   parameter int TICK_DIV = 50000000,
   parameter int DEB_CYC  = 500000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_btn_mode,
   input  logic       i_btn_inc,
   output logic [5:0] o_sec,
   output logic [5:0] o_min,
   output logic [4:0] o_hour,
   output logic [1:0] o_mode,
   output logic [5:0] o_dp,
   output logic       o_sec_tick
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int DW = (DEB_CYC  > 1) ? $clog2(DEB_CYC)  : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
   localparam logic [DW-1:0] DEB_MAX   = DW'(DEB_CYC - 1);

   localparam logic [1:0] ST_RUN  = 2'd0;
   localparam logic [1:0] ST_HOUR = 2'd1;
   localparam logic [1:0] ST_MIN  = 2'd2;
   localparam logic [1:0] ST_SEC  = 2'd3;

   // Button index 0 = mode, 1 = inc.
   logic [1:0]    sync1_q, sync1_d;
   logic [1:0]    sync2_q, sync2_d;
   logic [1:0]    deb_q, deb_d;
   logic [1:0]    deb_dly_q, deb_dly_d;
   logic [DW-1:0] cnt_q [2];
   logic [DW-1:0] cnt_d [2];
   logic [1:0]    press;

   logic [1:0]    state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [5:0]    sec_q, sec_d;
   logic [5:0]    min_q, min_d;
   logic [4:0]    hour_q, hour_d;
   logic [5:0]    dp_q, dp_d;
   logic          sec_tick;

   // ---------------------------------------------------------------------
   // Button conditioning: 2-flop synchronizer, then a level is accepted only
   // after it has differed from the current debounced level for DEB_CYC
   // consecutive cycles. Any return to the old level restarts the count.
   // ---------------------------------------------------------------------
   always_comb begin
      sync1_d   = {i_btn_inc, i_btn_mode};
      sync2_d   = sync1_q;
      deb_d     = deb_q;
      deb_dly_d = deb_q;
      for (int b = 0; b < 2; b++) begin
         cnt_d[b] = '0;
         if (sync2_q[b] != deb_q[b]) begin
            if (cnt_q[b] == DEB_MAX) begin
               deb_d[b] = sync2_q[b];
            end else begin
               cnt_d[b] = cnt_q[b] + 1'b1;
            end
         end
      end
   end

   assign press = deb_q & ~deb_dly_q;

   // ---------------------------------------------------------------------
   // Mode FSM, prescaler and time registers.
   // ---------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      presc_d  = '0;
      sec_d    = sec_q;
      min_d    = min_q;
      hour_d   = hour_q;
      sec_tick = 1'b0;

      if (state_q == ST_RUN) begin
         sec_tick = (presc_q == PRESC_MAX);
         presc_d  = sec_tick ? '0 : presc_q + 1'b1;
         if (sec_tick) begin
            // Full ripple carry in one edge: 23:59:59 -> 00:00:00.
            if (sec_q == 6'd59) begin
               sec_d = 6'd0;
               if (min_q == 6'd59) begin
                  min_d  = 6'd0;
                  hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
               end else begin
                  min_d = min_q + 6'd1;
               end
            end else begin
               sec_d = sec_q + 6'd1;
            end
         end
      end else if (press[1] && !press[0]) begin
         // Set mode: increment the selected field only, never carry.
         case (state_q)
            ST_HOUR: hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            ST_MIN:  min_d  = (min_q  == 6'd59) ? 6'd0 : min_q  + 6'd1;
            ST_SEC:  sec_d  = (sec_q  == 6'd59) ? 6'd0 : sec_q  + 6'd1;
            default: ;
         endcase
      end

      // Mode press wins over inc; the 2-bit state wraps SET_SEC -> RUN.
      // Prescaler restarts at 0 so the first tick after re-entering RUN
      // lands TICK_DIV edges later.
      if (press[0]) begin
         state_d = state_q + 2'd1;
         presc_d = '0;
      end
   end

   // Decimal points follow the next state so they change with o_mode.
   always_comb begin
      case (state_d)
         ST_HOUR: dp_d = 6'b110000;
         ST_MIN:  dp_d = 6'b001100;
         ST_SEC:  dp_d = 6'b000011;
         default: dp_d = 6'b000000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         deb_q     <= '0;
         deb_dly_q <= '0;
         for (int b = 0; b < 2; b++) begin
            cnt_q[b] <= '0;
         end
         state_q   <= ST_RUN;
         presc_q   <= '0;
         sec_q     <= '0;
         min_q     <= '0;
         hour_q    <= '0;
         dp_q      <= '0;
      end else begin
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         deb_q     <= deb_d;
         deb_dly_q <= deb_dly_d;
         for (int b = 0; b < 2; b++) begin
            cnt_q[b] <= cnt_d[b];
         end
         state_q   <= state_d;
         presc_q   <= presc_d;
         sec_q     <= sec_d;
         min_q     <= min_d;
         hour_q    <= hour_d;
         dp_q      <= dp_d;
      end
   end

   assign o_sec      = sec_q;
   assign o_min      = min_q;
   assign o_hour     = hour_q;
   assign o_mode     = state_q;
   assign o_dp       = dp_q;
   assign o_sec_tick = sec_tick;

endmodule

// File: tb/tb_hms_time_cnt.sv
// ----------------------------------------------------------------------------
// tb_hms_time_cnt
//   Self-checking bench for hms_time_cnt with TICK_DIV=10, DEB_CYC=4.
//   The reference keeps the time as a count of seconds since midnight, the
//   mode as an integer, and decides button acceptance from a window of the
//   most recent raw samples (a level is accepted once DEB_CYC consecutive
//   samples disagree with the accepted level; the synchronizer adds two
//   edges and the press acts one edge after acceptance).
// ----------------------------------------------------------------------------
module tb_hms_time_cnt;

   localparam int TICK_DIV = 10;
   localparam int DEB_CYC  = 4;
   localparam int HL       = DEB_CYC + 2;

   // ---------------- clock / reset ----------------
   logic       clk = 1'b0;
   logic       rst;
   logic       btn_mode;
   logic       btn_inc;
   logic [5:0] o_sec;
   logic [5:0] o_min;
   logic [4:0] o_hour;
   logic [1:0] o_mode;
   logic [5:0] o_dp;
   logic       o_sec_tick;

   always #5 clk = ~clk;

   hms_time_cnt #(.TICK_DIV(TICK_DIV), .DEB_CYC(DEB_CYC)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_btn_mode (btn_mode),
      .i_btn_inc  (btn_inc),
      .o_sec      (o_sec),
      .o_min      (o_min),
      .o_hour     (o_hour),
      .o_mode     (o_mode),
      .o_dp       (o_dp),
      .o_sec_tick (o_sec_tick)
   );

   // ---------------- scoreboard ----------------
   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   int tot_m;          // seconds since midnight
   int mode_m;         // 0 RUN, 1 hour, 2 min, 3 sec
   int since_tick;     // running edges since last tick / RUN entry
   bit hist_m [HL];    // raw samples, [0] newest
   bit hist_i [HL];
   bit deb_m_mode, deb_m_inc;
   bit pend_mode, pend_inc;

   function automatic int dp_of(input int m);
      case (m)
         1:       return 6'b110000;
         2:       return 6'b001100;
         3:       return 6'b000011;
         default: return 0;
      endcase
   endfunction

   task automatic model_reset();
      tot_m = 0; mode_m = 0; since_tick = 0;
      for (int k = 0; k < HL; k++) begin
         hist_m[k] = 1'b0;
         hist_i[k] = 1'b0;
      end
      deb_m_mode = 1'b0; deb_m_inc = 1'b0;
      pend_mode  = 1'b0; pend_inc  = 1'b0;
   endtask

   task automatic model_edge(input bit r, input bit bm, input bit bi);
      int  old_mode, h, mi, s;
      bit  flip;
      if (r) begin
         model_reset();
         return;
      end
      old_mode = mode_m;
      if (old_mode == 0) begin
         since_tick++;
         if (since_tick == TICK_DIV) begin
            tot_m      = (tot_m + 1) % 86400;
            since_tick = 0;
         end
      end
      if (pend_mode) begin
         mode_m     = (mode_m + 1) % 4;
         since_tick = 0;
      end else if (pend_inc && old_mode != 0) begin
         h = tot_m / 3600; mi = (tot_m / 60) % 60; s = tot_m % 60;
         if (old_mode == 1) h  = (h + 1) % 24;
         if (old_mode == 2) mi = (mi + 1) % 60;
         if (old_mode == 3) s  = (s + 1) % 60;
         tot_m = h * 3600 + mi * 60 + s;
      end
      for (int k = HL - 1; k > 0; k--) begin
         hist_m[k] = hist_m[k-1];
         hist_i[k] = hist_i[k-1];
      end
      hist_m[0] = bm;
      hist_i[0] = bi;
      // Acceptance at this edge uses the samples from edges n-(DEB_CYC+1)..n-2.
      flip = 1'b1;
      for (int k = 2; k < HL; k++) if (hist_m[k] == deb_m_mode) flip = 1'b0;
      if (flip) deb_m_mode = ~deb_m_mode;
      pend_mode = flip && deb_m_mode;
      flip = 1'b1;
      for (int k = 2; k < HL; k++) if (hist_i[k] == deb_m_inc) flip = 1'b0;
      if (flip) deb_m_inc = ~deb_m_inc;
      pend_inc = flip && deb_m_inc;
   endtask

   task automatic check_outputs();
      check("sec",  o_sec,  tot_m % 60);
      check("min",  o_min,  (tot_m / 60) % 60);
      check("hour", o_hour, tot_m / 3600);
      check("mode", o_mode, mode_m);
      check("dp",   o_dp,   dp_of(mode_m));
      check("tick", o_sec_tick, (mode_m == 0 && since_tick == TICK_DIV - 1) ? 1 : 0);
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle(input bit r, input bit bm, input bit bi);
      rst = r; btn_mode = bm; btn_inc = bi;
      @(posedge clk);
      model_edge(r, bm, bi);
      #1;
      check_outputs();
   endtask

   task automatic press(input bit m, input bit i, input int hold, input int gap);
      repeat (hold) cycle(1'b0, m, i);
      repeat (gap)  cycle(1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      repeat (2) cycle(1'b1, 1'b0, 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0;
      model_reset();

      // Reset state and free running.
      do_reset();
      check("rst_sec",  o_sec, 0);
      check("rst_mode", o_mode, 0);
      check("rst_dp",   o_dp, 0);
      check("rst_tick", o_sec_tick, 0);
      repeat (9) cycle(1'b0, 1'b0, 1'b0);
      check("first_tick", o_sec_tick, 1);
      cycle(1'b0, 1'b0, 1'b0);
      check("first_sec", o_sec, 1);
      repeat (590) cycle(1'b0, 1'b0, 1'b0);
      check("one_min_min", o_min, 1);
      check("one_min_sec", o_sec, 0);

      // Set 23:59:59 and roll over.
      do_reset();
      press(1'b1, 1'b0, 6, 8);
      repeat (23) press(1'b0, 1'b1, 6, 8);
      press(1'b1, 1'b0, 6, 8);
      repeat (59) press(1'b0, 1'b1, 6, 8);
      press(1'b1, 1'b0, 6, 8);
      repeat (59) press(1'b0, 1'b1, 6, 8);
      check("set_hour", o_hour, 23);
      check("set_min",  o_min, 59);
      check("set_sec",  o_sec, 59);
      press(1'b1, 1'b0, 6, 0);
      cycle(1'b0, 1'b0, 1'b0);
      check("back_run", o_mode, 0);
      repeat (9) cycle(1'b0, 1'b0, 1'b0);
      check("wrap_tick", o_sec_tick, 1);
      cycle(1'b0, 1'b0, 1'b0);
      check("wrap_hour", o_hour, 0);
      check("wrap_min",  o_min, 0);
      check("wrap_sec",  o_sec, 0);

      // Glitch rejection, then a held press steps exactly once.
      do_reset();
      repeat (3) cycle(1'b0, 1'b1, 1'b0);
      repeat (10) cycle(1'b0, 1'b0, 1'b0);
      check("glitch_mode", o_mode, 0);
      do_reset();
      for (int k = 1; k <= 10; k++) begin
         cycle(1'b0, 1'b1, 1'b0);
         if (k == 6) check("hold_e6", o_mode, 0);
         if (k == 7) check("hold_e7", o_mode, 1);
      end
      repeat (20) cycle(1'b0, 1'b0, 1'b0);
      check("hold_once", o_mode, 1);

      // SET_MIN: 61 increments wrap without carry.
      do_reset();
      press(1'b1, 1'b0, 6, 8);
      press(1'b1, 1'b0, 6, 8);
      repeat (61) press(1'b0, 1'b1, 5, 8);
      check("setmin_min",  o_min, 1);
      check("setmin_sec",  o_sec, 0);
      check("setmin_hour", o_hour, 0);
      check("setmin_dp",   o_dp, 6'b001100);

      // SET_HOUR: simultaneous mode+inc takes the mode step only.
      do_reset();
      press(1'b1, 1'b0, 6, 8);
      press(1'b1, 1'b1, 6, 8);
      check("both_mode", o_mode, 2);
      check("both_hour", o_hour, 0);

      // Reset in SET_SEC with mode held: held level counts as a fresh press.
      do_reset();
      repeat (3) press(1'b1, 1'b0, 6, 8);
      check("in_setsec", o_mode, 3);
      repeat (2) cycle(1'b0, 1'b1, 1'b0);
      repeat (2) cycle(1'b1, 1'b1, 1'b0);
      check("midrst_mode", o_mode, 0);
      check("midrst_dp",   o_dp, 0);
      for (int k = 1; k <= 7; k++) begin
         cycle(1'b0, 1'b1, 1'b0);
         if (k == 6) check("rel_e6", o_mode, 0);
         if (k == 7) check("rel_e7", o_mode, 1);
      end
      repeat (10) cycle(1'b0, 1'b0, 1'b0);

      // Randomized button activity with occasional resets.
      for (int seg = 0; seg < 500; seg++) begin
         bit bm, bi;
         int len;
         bm  = 1'($urandom_range(0, 1));
         bi  = 1'($urandom_range(0, 1));
         len = ($urandom_range(0, 7) == 0) ? $urandom_range(10, 30) : $urandom_range(1, 8);
         if ($urandom_range(0, 60) == 0) begin
            cycle(1'b1, bm, bi);
         end
         repeat (len) cycle(1'b0, bm, bi);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
